hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage core (fetch/decode/execute/memory/writeback).
- Issues per-stage stall, flush and bubble controls that the operand-forwarding network cannot hide:
  - load-use hazards
  - data-memory wait states
  - control redirects
  - trap drains
- Sits beside the forwarding unit. Drives the pipeline-register enables and valid-clears. Keeps a stall-cycle performance counter and a memory watchdog.

Parameters:
FLUSH_CYCLES, 2, cycles of full front-end flush after a trap (1..15)
MEM_TIMEOUT, 255, consecutive MEM_WAIT cycles before memoryTimeout sets (1..65535)

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high reset
fetchDecodeValid  input  1  FD register holds a valid instruction
fetchDecodeRegister1  input  5  rs1 of instruction in FD
fetchDecodeRegister2  input  5  rs2 of instruction in FD
fetchDecodeUsesRs1  input  1  instruction in FD reads rs1
fetchDecodeUsesRs2  input  1  instruction in FD reads rs2
decodeExecuteValid  input  1  DE register valid
decodeExecuteIsLoad  input  1  instruction in DE is a load (WB_MEM)
decodeExecuteDestinationRegister  input  5  rd of instruction in DE
memoryRequest  input  1  EM-stage instruction is accessing data memory
memoryReady  input  1  data memory completes access this cycle
executeRedirect  input  1  taken branch/jump resolved in execute
trapTaken  input  1  writeback commits a trap or mret
stallFetch  output  1  hold PC and FD register
stallDecode  output  1  hold DE register
stallExecute  output  1  hold EM register
flushFetchDecode  output  1  clear FD valid
flushDecodeExecute  output  1  clear DE valid
flushExecuteMemory  output  1  clear EM valid
bubbleDecodeExecute  output  1  insert NOP into DE (load-use)
memoryTimeout  output  1  sticky watchdog fault
stallCycleCount  output  32  saturating count of cycles with stallFetch=1

Behaviour:
- Single clock domain; all state updates on rising clock edge.
- While reset=1:
  - all stall outputs and bubbleDecodeExecute are 0.
  - all three flush outputs are 1.
  - state<=RUN, counters<=0, memoryTimeout<=0.
- Controls are combinational from state and inputs, valid in the same cycle (zero latency).
- loadUse is defined as:
  - decodeExecuteValid & decodeExecuteIsLoad & decodeExecuteDestinationRegister!=0 & fetchDecodeValid
  - & ((fetchDecodeUsesRs1 & rs1==rd) | (fetchDecodeUsesRs2 & rs2==rd)).
- Priority in every state: trapTaken > memory stall > executeRedirect > loadUse.
- State RUN:
  - trapTaken: assert all flushes; drainCount<=FLUSH_CYCLES-1; go TRAP_DRAIN (if FLUSH_CYCLES=1, go RUN).
  - memoryRequest & !memoryReady: assert stallFetch/stallDecode/stallExecute; go MEM_WAIT; waitCount<=1.
  - executeRedirect: assert flushFetchDecode and flushDecodeExecute; no stall; stay RUN.
  - loadUse: assert stallFetch, stallDecode and bubbleDecodeExecute for exactly one cycle. Next cycle the load has advanced to EM and is forwarded from MEM/WB.
  - otherwise: all controls 0.
- State MEM_WAIT:
  - Stall all three while memoryReady=0; waitCount increments, saturating at MEM_TIMEOUT.
  - When waitCount reaches MEM_TIMEOUT, set memoryTimeout=1; it stays set until reset. Stalling continues.
  - memoryReady=1: release all stalls this cycle; go RUN.
  - A redirect or loadUse present in the same cycle is handled as in RUN.
  - executeRedirect while waiting is ignored; execute is held, so the redirect re-presents after release.
- State TRAP_DRAIN:
  - Assert all flushes every cycle; stalls 0 so fetch proceeds from the trap vector.
  - drainCount decrements; at 0 go RUN.
  - trapTaken again reloads drainCount.
  - memoryRequest is ignored because EM is flushed.
- Simultaneous trapTaken and memory stall: trap wins, the outstanding access is abandoned, and the controller goes to TRAP_DRAIN.
- Register x0 never causes loadUse.
- stallCycleCount increments by 1 each cycle stallFetch=1 and saturates at 32'hFFFFFFFF without wrapping.
- Implementation is synthesizable; no latches; every output has a default assignment.

Test Plan:
- Reset asserted 3 cycles → flush*=1, stall*=0, stallCycleCount=0, memoryTimeout=0; after release all controls 0.
- DE: lw rd=5; FD: add rs1=5 with UsesRs1=1 → stallFetch=stallDecode=bubbleDecodeExecute=1 for exactly 1 cycle. Same case with rd=0 → no stall.
- memoryRequest=1, memoryReady=0 for 4 cycles then 1 → stalls high 4 cycles, low on ready cycle, stallCycleCount=4.
- MEM_TIMEOUT=3, memoryReady held 0 for 6 cycles → memoryTimeout rises on 3rd wait cycle and stays 1 after ready.
- executeRedirect=1 together with loadUse → flushFetchDecode=flushDecodeExecute=1, bubble=0, stall=0.
- trapTaken during MEM_WAIT with FLUSH_CYCLES=2 → all flushes high 2 cycles, stalls 0, then RUN with controls 0.

Source files
------------

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// hazard_controller : stall / flush / bubble sequencing for the 5-stage core
// Rev 1.0
// ============================================================================
module hazard_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchDecodeValid,
  input  logic [4:0]  fetchDecodeRegister1,
  input  logic [4:0]  fetchDecodeRegister2,
  input  logic        fetchDecodeUsesRs1,
  input  logic        fetchDecodeUsesRs2,
  input  logic        decodeExecuteValid,
  input  logic        decodeExecuteIsLoad,
  input  logic [4:0]  decodeExecuteDestinationRegister,
  input  logic        memoryRequest,
  input  logic        memoryReady,
  input  logic        executeRedirect,
  input  logic        trapTaken,
  output logic        stallFetch,
  output logic        stallDecode,
  output logic        stallExecute,
  output logic        flushFetchDecode,
  output logic        flushDecodeExecute,
  output logic        flushExecuteMemory,
  output logic        bubbleDecodeExecute,
  output logic        memoryTimeout,
  output logic [31:0] stallCycleCount
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_TRAP_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0]  c_DRAIN_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] c_WAIT_MAX     = 16'(MEM_TIMEOUT);
  localparam logic [31:0] c_CNT_MAX      = 32'hFFFF_FFFF;

  state_t      r_state;
  state_t      w_stateNext;
  logic [3:0]  r_drainCount;
  logic [3:0]  w_drainNext;
  logic [15:0] r_waitCount;
  logic [15:0] w_waitNext;
  logic        r_timeout;
  logic        w_timeoutHit;
  logic        r_bubbled;
  logic [31:0] r_stallCount;
  logic        w_rs1Hit;
  logic        w_rs2Hit;
  logic        w_loadUse;
  logic        w_memStall;

  assign w_rs1Hit = fetchDecodeUsesRs1 && (fetchDecodeRegister1 == decodeExecuteDestinationRegister);
  assign w_rs2Hit = fetchDecodeUsesRs2 && (fetchDecodeRegister2 == decodeExecuteDestinationRegister);

  // The cycle after a bubble the load has moved on to EM, so a still-matching
  // FD/DE pair must not re-trigger the stall.
  assign w_loadUse = decodeExecuteValid && decodeExecuteIsLoad
                  && (decodeExecuteDestinationRegister != 5'd0)
                  && fetchDecodeValid && (w_rs1Hit || w_rs2Hit) && !r_bubbled;

  assign w_memStall = (r_state == ST_MEM_WAIT) ? !memoryReady
                                               : (memoryRequest && !memoryReady);

  assign stallCycleCount = r_stallCount;

  always_comb begin
    w_stateNext         = r_state;
    w_drainNext         = r_drainCount;
    w_waitNext          = r_waitCount;
    w_timeoutHit        = 1'b0;
    stallFetch          = 1'b0;
    stallDecode         = 1'b0;
    stallExecute        = 1'b0;
    flushFetchDecode    = 1'b0;
    flushDecodeExecute  = 1'b0;
    flushExecuteMemory  = 1'b0;
    bubbleDecodeExecute = 1'b0;

    if (reset) begin
      flushFetchDecode   = 1'b1;
      flushDecodeExecute = 1'b1;
      flushExecuteMemory = 1'b1;
    end else begin
      case (r_state)
        ST_TRAP_DRAIN: begin
          flushFetchDecode   = 1'b1;
          flushDecodeExecute = 1'b1;
          flushExecuteMemory = 1'b1;
          if (trapTaken) begin
            w_drainNext = c_DRAIN_RELOAD;
          end else if (r_drainCount <= 4'd1) begin
            w_drainNext = 4'd0;
            w_stateNext = ST_RUN;
          end else begin
            w_drainNext = r_drainCount - 4'd1;
          end
        end
        default: begin
          if (trapTaken) begin
            flushFetchDecode   = 1'b1;
            flushDecodeExecute = 1'b1;
            flushExecuteMemory = 1'b1;
            w_drainNext        = c_DRAIN_RELOAD;
            w_stateNext        = (FLUSH_CYCLES > 1) ? ST_TRAP_DRAIN : ST_RUN;
          end else if (w_memStall) begin
            stallFetch   = 1'b1;
            stallDecode  = 1'b1;
            stallExecute = 1'b1;
            w_stateNext  = ST_MEM_WAIT;
            if (r_state != ST_MEM_WAIT)
              w_waitNext = 16'd1;
            else if (r_waitCount >= c_WAIT_MAX)
              w_waitNext = c_WAIT_MAX;
            else
              w_waitNext = r_waitCount + 16'd1;
            // Flag is visible in the very wait cycle that reaches the limit.
            w_timeoutHit = (w_waitNext >= c_WAIT_MAX);
          end else begin
            w_stateNext = ST_RUN;
            if (executeRedirect) begin
              flushFetchDecode   = 1'b1;
              flushDecodeExecute = 1'b1;
            end else if (w_loadUse) begin
              stallFetch          = 1'b1;
              stallDecode         = 1'b1;
              bubbleDecodeExecute = 1'b1;
            end
          end
        end
      endcase
    end

    memoryTimeout = !reset && (r_timeout || w_timeoutHit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_drainCount <= 4'd0;
      r_waitCount  <= 16'd0;
      r_timeout    <= 1'b0;
      r_bubbled    <= 1'b0;
      r_stallCount <= 32'd0;
    end else begin
      r_state      <= w_stateNext;
      r_drainCount <= w_drainNext;
      r_waitCount  <= w_waitNext;
      r_timeout    <= r_timeout || w_timeoutHit;
      r_bubbled    <= bubbleDecodeExecute;
      if (stallFetch && (r_stallCount != c_CNT_MAX))
        r_stallCount <= r_stallCount + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// tb_hazard_controller : scenario bench for hazard_controller
// Rev 1.0
// ============================================================================
module tb_hazard_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetchDecodeValid = 1'b0;
  logic [4:0]  fetchDecodeRegister1 = 5'd0;
  logic [4:0]  fetchDecodeRegister2 = 5'd0;
  logic        fetchDecodeUsesRs1 = 1'b0;
  logic        fetchDecodeUsesRs2 = 1'b0;
  logic        decodeExecuteValid = 1'b0;
  logic        decodeExecuteIsLoad = 1'b0;
  logic [4:0]  decodeExecuteDestinationRegister = 5'd0;
  logic        memoryRequest = 1'b0;
  logic        memoryReady = 1'b0;
  logic        executeRedirect = 1'b0;
  logic        trapTaken = 1'b0;
  logic        stallFetch, stallDecode, stallExecute;
  logic        flushFetchDecode, flushDecodeExecute, flushExecuteMemory;
  logic        bubbleDecodeExecute, memoryTimeout;
  logic [31:0] stallCycleCount;

  hazard_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3)) dut (
    .clock(clock), .reset(reset),
    .fetchDecodeValid(fetchDecodeValid),
    .fetchDecodeRegister1(fetchDecodeRegister1),
    .fetchDecodeRegister2(fetchDecodeRegister2),
    .fetchDecodeUsesRs1(fetchDecodeUsesRs1),
    .fetchDecodeUsesRs2(fetchDecodeUsesRs2),
    .decodeExecuteValid(decodeExecuteValid),
    .decodeExecuteIsLoad(decodeExecuteIsLoad),
    .decodeExecuteDestinationRegister(decodeExecuteDestinationRegister),
    .memoryRequest(memoryRequest), .memoryReady(memoryReady),
    .executeRedirect(executeRedirect), .trapTaken(trapTaken),
    .stallFetch(stallFetch), .stallDecode(stallDecode), .stallExecute(stallExecute),
    .flushFetchDecode(flushFetchDecode), .flushDecodeExecute(flushDecodeExecute),
    .flushExecuteMemory(flushExecuteMemory),
    .bubbleDecodeExecute(bubbleDecodeExecute), .memoryTimeout(memoryTimeout),
    .stallCycleCount(stallCycleCount)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       fdv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       dev;
    logic       del;
    logic [4:0] rd;
    logic       mreq;
    logic       mrdy;
    logic       redir;
    logic       trap;
  } stim_t;

  typedef struct packed {
    logic [7:0]  ctl;   // {stallF,stallD,stallE,flushFD,flushDE,flushEM,bubble,timeout}
    logic [31:0] cnt;
  } exp_t;

  localparam logic [7:0] c_NONE = 8'b000_000_0_0;
  localparam logic [7:0] c_LU   = 8'b110_000_1_0;
  localparam logic [7:0] c_MEM  = 8'b111_000_0_0;
  localparam logic [7:0] c_RDR  = 8'b000_110_0_0;
  localparam logic [7:0] c_FLSH = 8'b000_111_0_0;
  localparam logic [7:0] c_TMO  = 8'b000_000_0_1;

  exp_t        sb[$];
  logic [31:0] exp_cnt = 32'd0;
  int          total = 0;
  int          bad = 0;

  function automatic stim_t st_lu(input logic [4:0] r);
    stim_t s;
    s = '0;
    s.fdv = 1'b1; s.rs1 = r; s.u1 = 1'b1;
    s.dev = 1'b1; s.del = 1'b1; s.rd = r;
    return s;
  endfunction

  function automatic stim_t st_mem(input logic rdy);
    stim_t s;
    s = '0;
    s.mreq = 1'b1; s.mrdy = rdy;
    return s;
  endfunction

  function automatic exp_t observe();
    return {stallFetch, stallDecode, stallExecute, flushFetchDecode, flushDecodeExecute,
            flushExecuteMemory, bubbleDecodeExecute, memoryTimeout, stallCycleCount};
  endfunction

  task automatic drive(input stim_t s);
    fetchDecodeValid = s.fdv;
    fetchDecodeRegister1 = s.rs1;
    fetchDecodeRegister2 = s.rs2;
    fetchDecodeUsesRs1 = s.u1;
    fetchDecodeUsesRs2 = s.u2;
    decodeExecuteValid = s.dev;
    decodeExecuteIsLoad = s.del;
    decodeExecuteDestinationRegister = s.rd;
    memoryRequest = s.mreq;
    memoryReady = s.mrdy;
    executeRedirect = s.redir;
    trapTaken = s.trap;
  endtask

  // Expected counter value is the number of stall cycles seen before this one.
  task automatic push_exp(input logic [7:0] ctl);
    sb.push_back({ctl, exp_cnt});
    if (ctl[7] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_cnt = 32'd0;
    sb.delete();
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t got, want;
    s = st_lu(5'd5); s.mreq = 1'b1; s.redir = 1'b1; s.trap = 1'b1;
    reset = 1'b1;
    drive(s);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin reset = 1'b0; drive('0); end
      push_exp(i < 2 ? c_FLSH : c_NONE);
      @(negedge clock);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset cyc%0d actual=%h required=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [7:0] e[$]; stim_t t; exp_t got, want;
    s.push_back(st_lu(5'd5)); e.push_back(c_LU);
    s.push_back(st_lu(5'd5)); e.push_back(c_NONE);
    s.push_back('0);          e.push_back(c_NONE);
    s.push_back(st_lu(5'd0)); e.push_back(c_NONE);
    t = st_lu(5'd7); t.rs1 = 5'd3; t.rs2 = 5'd7; t.u2 = 1'b1;
    s.push_back(t);           e.push_back(c_LU);
    s.push_back('0);          e.push_back(c_NONE);
    t = st_lu(5'd5); t.u1 = 1'b0;
    s.push_back(t);           e.push_back(c_NONE);
    t = st_lu(5'd5); t.del = 1'b0;
    s.push_back(t);           e.push_back(c_NONE);
    foreach (s[i]) begin
      drive(s[i]); push_exp(e[i]);
      @(negedge clock);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL load_use cyc%0d actual=%h required=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[$]; logic [7:0] e[$]; exp_t got, want;
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM | c_TMO);
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM | c_TMO);
    s.push_back(st_mem(1'b1)); e.push_back(c_TMO);
    s.push_back('0);           e.push_back(c_TMO);
    foreach (s[i]) begin
      drive(s[i]); push_exp(e[i]);
      @(negedge clock);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL mem_wait cyc%0d actual=%h required=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t s[$]; logic [7:0] e[$]; stim_t t; exp_t got, want;
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    t = st_mem(1'b0); t.redir = 1'b1;
    s.push_back(t);            e.push_back(c_MEM);
    for (int k = 0; k < 4; k++) begin
      s.push_back(st_mem(1'b0)); e.push_back(c_MEM | c_TMO);
    end
    t = st_mem(1'b1); t.redir = 1'b1;
    s.push_back(t);            e.push_back(c_RDR | c_TMO);
    s.push_back('0);           e.push_back(c_TMO);
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM | c_TMO);
    s.push_back(st_mem(1'b1)); e.push_back(c_TMO);
    foreach (s[i]) begin
      drive(s[i]); push_exp(e[i]);
      @(negedge clock);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL timeout cyc%0d actual=%h required=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_redirect();
    stim_t s[$]; logic [7:0] e[$]; stim_t t; exp_t got, want;
    t = st_lu(5'd9); t.redir = 1'b1;
    s.push_back(t);            e.push_back(c_RDR);
    s.push_back(st_lu(5'd9));  e.push_back(c_LU);
    s.push_back(st_lu(5'd9));  e.push_back(c_NONE);
    s.push_back('0);           e.push_back(c_NONE);
    t = st_lu(5'd9); t.redir = 1'b1; t.mreq = 1'b1;
    s.push_back(t);            e.push_back(c_MEM);
    s.push_back(st_mem(1'b1)); e.push_back(c_NONE);
    t = '0; t.redir = 1'b1;
    s.push_back(t);            e.push_back(c_RDR);
    foreach (s[i]) begin
      drive(s[i]); push_exp(e[i]);
      @(negedge clock);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL redirect cyc%0d actual=%h required=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_trap();
    stim_t s[$]; logic [7:0] e[$]; stim_t t; exp_t got, want;
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    t = st_mem(1'b0); t.trap = 1'b1;
    s.push_back(t);            e.push_back(c_FLSH);
    s.push_back(st_mem(1'b0)); e.push_back(c_FLSH);
    s.push_back('0);           e.push_back(c_NONE);
    t = '0; t.trap = 1'b1;
    s.push_back(t);            e.push_back(c_FLSH);
    s.push_back(t);            e.push_back(c_FLSH);
    s.push_back('0);           e.push_back(c_FLSH);
    s.push_back('0);           e.push_back(c_NONE);
    t = st_lu(5'd4); t.trap = 1'b1; t.redir = 1'b1;
    s.push_back(t);            e.push_back(c_FLSH);
    s.push_back(st_lu(5'd4));  e.push_back(c_FLSH);
    s.push_back(st_lu(5'd4));  e.push_back(c_LU);
    s.push_back('0);           e.push_back(c_NONE);
    foreach (s[i]) begin
      drive(s[i]); push_exp(e[i]);
      @(negedge clock);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL trap cyc%0d actual=%h required=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$]; logic [7:0] e[$]; stim_t t; exp_t got, want;
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    t = st_lu(5'd12); t.mreq = 1'b1; t.mrdy = 1'b1;
    s.push_back(t);            e.push_back(c_LU);
    s.push_back(st_lu(5'd12)); e.push_back(c_NONE);
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    s.push_back(st_mem(1'b1)); e.push_back(c_NONE);
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    s.push_back(st_mem(1'b0)); e.push_back(c_MEM);
    s.push_back(st_mem(1'b1)); e.push_back(c_NONE);
    s.push_back('0);           e.push_back(c_NONE);
    foreach (s[i]) begin
      drive(s[i]); push_exp(e[i]);
      @(negedge clock);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL back_to_back cyc%0d actual=%h required=%h", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_load_use();
    do_reset();
    test_mem_wait();
    do_reset();
    test_timeout();
    do_reset();
    test_redirect();
    do_reset();
    test_trap();
    do_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
